// File: rtl/coinc_pkg.sv
// Shared phase codes and tracking-FSM state encoding for the coinc block.
package coinc_pkg;

    localparam logic [3:0] PH_IDLE = 4'd0;
    localparam logic [3:0] PH_ALO  = 4'd1;
    localparam logic [3:0] PH_AHI  = 4'd2;
    localparam logic [3:0] PH_BLO  = 4'd3;
    localparam logic [3:0] PH_BHI  = 4'd4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A_LO = 3'd1,
        A_HI = 3'd2,
        B_LO = 3'd3,
        B_HI = 3'd4
    } state_t;

endpackage

// File: rtl/coinc_decode.sv
// Combinational decode of the sequencer phase code into chip enables and byte selects.
module coinc_decode
    import coinc_pkg::*;
(
    input  logic [3:0] cnt,
    output logic       cea,
    output logic       ceb,
    output logic       bh,
    output logic       bl
);

    always_comb begin
        cea = 1'b0;
        ceb = 1'b0;
        bh  = 1'b0;
        bl  = 1'b0;
        case (cnt)
            PH_ALO: begin cea = 1'b1; bl = 1'b1; end
            PH_AHI: begin cea = 1'b1; bh = 1'b1; end
            PH_BLO: begin ceb = 1'b1; bl = 1'b1; end
            PH_BHI: begin ceb = 1'b1; bh = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/coinc.sv
// Coincidence read sequencer tracker: registered selects, A/B sequence FSM and DX counter.
// Define COINC_SATURATE_EN to make DX hold at all-ones instead of wrapping.
module coinc
    import coinc_pkg::*;
#(
    parameter int unsigned DX_W = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [3:0]      cnt,
    output logic [DX_W-1:0] DX,
    output logic            cea,
    output logic            ceb,
    output logic            bh,
    output logic            bl,
    output logic            ocx,
    output logic            ocy
);

    state_t          state, state_n;
    logic            dec_cea, dec_ceb, dec_bh, dec_bl;
    logic            ocx_n, ocy_n;
    logic [DX_W-1:0] dx_inc;

    coinc_decode u_decode (
        .cnt (cnt),
        .cea (dec_cea),
        .ceb (dec_ceb),
        .bh  (dec_bh),
        .bl  (dec_bl)
    );

    // A held code keeps its state; pulses fire only on the advancing transition.
    always_comb begin
        state_n = IDLE;
        ocx_n   = 1'b0;
        ocy_n   = 1'b0;
        if (cnt == PH_ALO) begin
            state_n = A_LO;
        end else if (cnt == PH_AHI && (state == A_LO || state == A_HI)) begin
            state_n = A_HI;
            ocx_n   = (state == A_LO);
        end else if (cnt == PH_BLO && (state == A_HI || state == B_LO)) begin
            state_n = B_LO;
        end else if (cnt == PH_BHI && (state == B_LO || state == B_HI)) begin
            state_n = B_HI;
            ocy_n   = (state == B_LO);
        end
    end

    always_comb begin
`ifdef COINC_SATURATE_EN
        dx_inc = (DX == '1) ? DX : DX + 1'b1;
`else
        dx_inc = DX + 1'b1;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            DX    <= '0;
            cea   <= 1'b0;
            ceb   <= 1'b0;
            bh    <= 1'b0;
            bl    <= 1'b0;
            ocx   <= 1'b0;
            ocy   <= 1'b0;
        end else begin
            state <= state_n;
            cea   <= dec_cea;
            ceb   <= dec_ceb;
            bh    <= dec_bh;
            bl    <= dec_bl;
            ocx   <= ocx_n;
            ocy   <= ocy_n;
            if (ocy_n) begin
                DX <= dx_inc;
            end
        end
    end

endmodule

// File: tb/tb_coinc.sv
// Directed self-checking bench for coinc; a narrow DX_W=4 instance exercises counter wrap/saturation.
module tb_coinc;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  cnt = 4'd0;
    logic [15:0] DX;
    logic        cea, ceb, bh, bl, ocx, ocy;
    logic [3:0]  dxs;
    logic        s_cea, s_ceb, s_bh, s_bl, s_ocx, s_ocy;

    int checks = 0;
    int errors = 0;
    int nocx   = 0;
    int nocy   = 0;

    coinc #(.DX_W(16)) dut (
        .CLK (CLK), .RST (RST), .cnt (cnt), .DX (DX),
        .cea (cea), .ceb (ceb), .bh (bh), .bl (bl), .ocx (ocx), .ocy (ocy)
    );

    coinc #(.DX_W(4)) dut_s (
        .CLK (CLK), .RST (RST), .cnt (cnt), .DX (dxs),
        .cea (s_cea), .ceb (s_ceb), .bh (s_bh), .bl (s_bl), .ocx (s_ocx), .ocy (s_ocy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [5:0] outs();
        return {cea, ceb, bh, bl, ocx, ocy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one code, let one edge sample it, then observe 1 time unit later.
    task automatic tick(input logic [3:0] c);
        cnt = c;
        @(posedge CLK);
        #1;
        if (ocx === 1'b1) nocx++;
        if (ocy === 1'b1) nocy++;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cnt = 4'd0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        nocx = 0;
        nocy = 0;
    endtask

    task automatic full_seq();
        tick(4'd1); tick(4'd2); tick(4'd3); tick(4'd4); tick(4'd0);
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_outs", 32'(outs()), 32'h0);
        chk("rst_dx", 32'(DX), 32'h0);

        // single sequence 0,1,2,3,4,0
        tick(4'd0); chk("s0_outs", 32'(outs()), 32'b000000);
        tick(4'd1); chk("s1_outs", 32'(outs()), 32'b100100);
        tick(4'd2); chk("s2_outs", 32'(outs()), 32'b101010);
        tick(4'd3); chk("s3_outs", 32'(outs()), 32'b010100);
        tick(4'd4); chk("s4_outs", 32'(outs()), 32'b011001);
        chk("s4_dx", 32'(DX), 32'h1);
        tick(4'd0); chk("s5_outs", 32'(outs()), 32'b000000);
        chk("s5_dx", 32'(DX), 32'h1);
        chk("s_nocx", nocx, 1);
        chk("s_nocy", nocy, 1);

        // two back-to-back sequences
        nocx = 0; nocy = 0;
        tick(4'd1); tick(4'd2); tick(4'd3); tick(4'd4);
        tick(4'd1); tick(4'd2); tick(4'd3); tick(4'd4); tick(4'd0);
        chk("b2b_dx", 32'(DX), 32'h3);
        chk("b2b_nocx", nocx, 2);
        chk("b2b_nocy", nocy, 2);

        // cnt=2 held for 3 cycles
        nocx = 0; nocy = 0;
        tick(4'd1); tick(4'd2); tick(4'd2);
        chk("hold_outs", 32'(outs()), 32'b101000);
        tick(4'd2); tick(4'd0);
        chk("hold_nocx", nocx, 1);

        // out-of-order 1,3,4 then 7
        nocx = 0; nocy = 0;
        tick(4'd1); chk("ooo1_outs", 32'(outs()), 32'b100100);
        tick(4'd3); chk("ooo3_outs", 32'(outs()), 32'b010100);
        tick(4'd4); chk("ooo4_outs", 32'(outs()), 32'b011000);
        tick(4'd7); chk("ooo7_outs", 32'(outs()), 32'b000000);
        chk("ooo_dx", 32'(DX), 32'h3);
        chk("ooo_pulses", nocx + nocy, 0);

        // restart at A_LO mid-sequence
        nocx = 0; nocy = 0;
        tick(4'd1); tick(4'd2); tick(4'd3); tick(4'd1);
        chk("rs_nocx_a", nocx, 1);
        chk("rs_outs", 32'(outs()), 32'b100100);
        tick(4'd2); chk("rs_outs2", 32'(outs()), 32'b101010);
        tick(4'd0);
        chk("rs_nocx_b", nocx, 2);
        chk("rs_nocy", nocy, 0);

        // reset asserted while in B_LO
        do_reset();
        tick(4'd1); tick(4'd2); tick(4'd3);
        RST = 1'b1;
        tick(4'd3);
        chk("rmid_outs", 32'(outs()), 32'b000000);
        RST = 1'b0;
        nocy = 0;
        tick(4'd4);
        chk("rmid_b_outs", 32'(outs()), 32'b011000);
        tick(4'd0);
        chk("rmid_nocy", nocy, 0);
        chk("rmid_dx", 32'(DX), 32'h0);

        // wrap / saturation on the narrow instance
        do_reset();
        chk("w_rst_dxs", 32'(dxs), 32'h0);
        for (int i = 0; i < 15; i++) full_seq();
        chk("w_dxs_max", 32'(dxs), 32'hF);
        tick(4'd1); tick(4'd2); tick(4'd3); tick(4'd4);
        chk("w_ocy_at_top", 32'(s_ocy), 32'h1);
`ifdef COINC_SATURATE_EN
        chk("w_dxs_sat", 32'(dxs), 32'hF);
`else
        chk("w_dxs_wrap", 32'(dxs), 32'h0);
`endif
        chk("w_dx16", 32'(DX), 32'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
